// File: rtl/present80_key_schedule.sv
`default_nettype none
// ============================================================================
// Module      : present80_key_schedule
// Description : PRESENT-80 round-key generator. It expands one 80-bit master
//               key into 32 stored 64-bit round keys (K1..K32), producing one
//               key per cycle. A separate random-access read port returns any
//               stored key with one cycle of latency.
// Revision    : 1.0 - initial release
// ============================================================================
module present80_key_schedule (
  input  logic        clk,
  input  logic        reset,
  input  logic [79:0] master_key,
  input  logic        ks_start,
  output logic        ks_busy,
  output logic        ks_done,
  output logic        keys_ready,
  input  logic        rd_en,
  input  logic [4:0]  rd_idx,
  output logic [63:0] rd_data,
  output logic        rd_valid
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_GEN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Round counter i runs 1..32, so it needs six bits. Only its low five bits
  // are ever mixed into the key, because the update is skipped when i = 32.
  localparam logic [5:0] C_LAST_ROUND = 6'd32;
  localparam logic [5:0] C_FIRST_ROUND = 6'd1;

  // --------------------------------------------------------------------------
  // PRESENT 4-bit S-box
  // --------------------------------------------------------------------------
  function automatic logic [3:0] sbox(input logic [3:0] x);
    logic [3:0] y;
    case (x)
      4'h0: y = 4'hC;
      4'h1: y = 4'h5;
      4'h2: y = 4'h6;
      4'h3: y = 4'hB;
      4'h4: y = 4'h9;
      4'h5: y = 4'h0;
      4'h6: y = 4'hA;
      4'h7: y = 4'hD;
      4'h8: y = 4'h3;
      4'h9: y = 4'hE;
      4'hA: y = 4'hF;
      4'hB: y = 4'h8;
      4'hC: y = 4'h4;
      4'hD: y = 4'h7;
      4'hE: y = 4'h1;
      default: y = 4'h2;
    endcase
    return y;
  endfunction

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  state_t      state_q,      state_d;
  logic [79:0] key_q,        key_d;
  logic [5:0]  round_q,      round_d;
  logic        busy_q,       busy_d;
  logic        done_q,       done_d;
  logic        ready_q,      ready_d;
  logic [63:0] rd_data_q,    rd_data_d;
  logic        rd_valid_q,   rd_valid_d;

  // Round-key storage: deliberately left without reset; keys_ready gates
  // every read so stale contents are never exposed.
  logic [63:0] key_mem_q [32];

  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [79:0] key_rot;
  logic [79:0] key_next;

  // One round of the key update: rotate left by 61, S-box the top nibble,
  // and fold the 5-bit round number into bits 19..15.
  always_comb begin
    key_rot  = {key_q[18:0], key_q[79:19]};
    key_next = {sbox(key_rot[79:76]),
                key_rot[75:20],
                key_rot[19:15] ^ round_q[4:0],
                key_rot[14:0]};
  end

  // Control FSM next-state, key register and status-flag updates.
  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    round_d = round_q;
    busy_d  = busy_q;
    done_d  = done_q;
    ready_d = ready_q;
    wr_en   = 1'b0;
    // Entry i-1; for i = 32 the low five bits are zero and wrap to 31.
    wr_addr = round_q[4:0] - 5'd1;

    case (state_q)
      S_IDLE: begin
        done_d = 1'b0;
        if (ks_start) begin
          key_d   = master_key;
          round_d = C_FIRST_ROUND;
          ready_d = 1'b0;
          busy_d  = 1'b1;
          state_d = S_GEN;
        end
      end

      S_GEN: begin
        wr_en = 1'b1;
        if (round_q == C_LAST_ROUND) begin
          // Final entry written; no further key update is needed.
          busy_d  = 1'b0;
          done_d  = 1'b1;
          ready_d = 1'b1;
          state_d = S_DONE;
        end else begin
          key_d   = key_next;
          round_d = round_q + 6'd1;
        end
      end

      S_DONE: begin
        done_d  = 1'b0;
        state_d = S_IDLE;
      end

      default: begin
        busy_d  = 1'b0;
        done_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  // Read port: keys_ready is sampled before any same-cycle restart clears
  // it, so a read issued alongside ks_start still returns the old key.
  always_comb begin
    rd_valid_d = rd_en & ready_q;
    rd_data_d  = rd_data_q;
    if (rd_en) begin
      rd_data_d = ready_q ? key_mem_q[rd_idx] : 64'd0;
    end
  end

  // Control and read-port registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      key_q      <= 80'd0;
      round_q    <= 6'd0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ready_q    <= 1'b0;
      rd_data_q  <= 64'd0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      key_q      <= key_d;
      round_q    <= round_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      ready_q    <= ready_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  // Round-key storage write: the top 64 bits of the current key register.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      key_mem_q[wr_addr] <= key_q[79:16];
    end
  end

  assign ks_busy    = busy_q;
  assign ks_done    = done_q;
  assign keys_ready = ready_q;
  assign rd_data    = rd_data_q;
  assign rd_valid   = rd_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_present80_key_schedule.sv
`default_nettype none
// ============================================================================
// Module      : tb_present80_key_schedule
// Description : Self-checking bench for present80_key_schedule against a
//               behavioural key-expansion model and a PRESENT-80 cipher.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_present80_key_schedule;

  logic        clk = 1'b0;
  logic        reset;
  logic [79:0] master_key;
  logic        ks_start;
  logic        ks_busy;
  logic        ks_done;
  logic        keys_ready;
  logic        rd_en;
  logic [4:0]  rd_idx;
  logic [63:0] rd_data;
  logic        rd_valid;

  int n_checks = 0;
  int n_fail   = 0;

  logic [63:0] exp_keys [32];
  logic [63:0] got_keys [32];
  logic [63:0] sbox_tab = 64'h21748FE3DA09B65C;  // nibble n holds S(n)

  present80_key_schedule dut (
    .clk        (clk),
    .reset      (reset),
    .master_key (master_key),
    .ks_start   (ks_start),
    .ks_busy    (ks_busy),
    .ks_done    (ks_done),
    .keys_ready (keys_ready),
    .rd_en      (rd_en),
    .rd_idx     (rd_idx),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] sb(input logic [3:0] x);
    return sbox_tab[int'(x)*4 +: 4];
  endfunction

  // Key expansion straight from the PRESENT-80 rules.
  task automatic compute_model(input logic [79:0] mk);
    logic [79:0] k;
    k = mk;
    for (int r = 1; r <= 32; r++) begin
      exp_keys[r-1] = k[79:16];
      if (r < 32) begin
        k = (k << 61) | (k >> 19);
        k[79:76] = sb(k[79:76]);
        k[19:15] = k[19:15] ^ 5'(r);
      end
    end
  endtask

  // PRESENT-80 encryption using the keys read back into got_keys.
  function automatic logic [63:0] present_enc(input logic [63:0] pt);
    logic [63:0] s, t;
    s = pt;
    for (int r = 0; r < 31; r++) begin
      s = s ^ got_keys[r];
      for (int n = 0; n < 16; n++) s[4*n +: 4] = sb(s[4*n +: 4]);
      t = '0;
      for (int b = 0; b < 63; b++) t[(16*b) % 63] = s[b];
      t[63] = s[63];
      s = t;
    end
    return s ^ got_keys[31];
  endfunction

  // Waits for ks_done after the accepting edge; optionally pulses ks_start
  // with another key at cycle inj to show it is ignored.
  task automatic wait_done(input int inj, input logic [79:0] alt,
                           output int lat, output int busy_cnt);
    lat = 1;
    busy_cnt = 0;
    while (ks_done !== 1'b1 && lat < 100) begin
      if (ks_busy === 1'b1) busy_cnt++;
      if (lat == inj) begin
        ks_start   = 1'b1;
        master_key = alt;
      end else begin
        ks_start = 1'b0;
      end
      tick();
      lat++;
    end
    ks_start = 1'b0;
  endtask

  task automatic run_gen(input logic [79:0] mk, input int inj,
                         input logic [79:0] alt,
                         output int lat, output int busy_cnt);
    master_key = mk;
    ks_start   = 1'b1;
    tick();
    ks_start   = 1'b0;
    wait_done(inj, alt, lat, busy_cnt);
  endtask

  task automatic read_fwd(output int valid_cnt);
    valid_cnt = 0;
    for (int j = 0; j < 32; j++) begin
      rd_en  = 1'b1;
      rd_idx = 5'(j);
      tick();
      got_keys[j] = rd_data;
      if (rd_valid === 1'b1) valid_cnt++;
    end
    rd_en = 1'b0;
  endtask

  task automatic check_keys(input string name);
    int bad;
    int vc;
    read_fwd(vc);
    bad = 0;
    for (int j = 0; j < 32; j++) if (got_keys[j] !== exp_keys[j]) bad++;
    n_checks++;
    if (bad != 0 || vc != 32) begin
      n_fail++;
      $display("FAIL %s: %0d keys wrong, %0d valid, required 0 wrong 32 valid",
               name, bad, vc);
    end
  endtask

  task automatic check_gen(input string name, input int lat, input int busy_cnt);
    n_checks++;
    if (lat != 33 || busy_cnt != 32) begin
      n_fail++;
      $display("FAIL %s: latency %0d busy %0d, required 33 and 32", name, lat, busy_cnt);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; ks_start = 1'b0; master_key = '0; rd_en = 1'b0; rd_idx = '0;
    #1;
    n_checks++;
    if ({ks_busy, ks_done, keys_ready, rd_valid} !== 4'b0 || rd_data !== 64'd0) begin
      n_fail++;
      $display("FAIL reset_state: busy/done/ready/valid %b data %h, required 0000 and 0",
               {ks_busy, ks_done, keys_ready, rd_valid}, rd_data);
    end
    tick(); tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_read_before_gen();
    rd_en = 1'b1; rd_idx = 5'd7;
    tick();
    rd_en = 1'b0;
    n_checks++;
    if (rd_valid !== 1'b0 || rd_data !== 64'd0) begin
      n_fail++;
      $display("FAIL read_before_gen: valid %b data %h, required 0 and 0", rd_valid, rd_data);
    end
  endtask

  task automatic test_zero_key();
    int lat, bc;
    run_gen(80'd0, 0, 80'd0, lat, bc);
    check_gen("zero_latency", lat, bc);
    tick();
    n_checks++;
    if (ks_done !== 1'b0 || keys_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL done_pulse: done %b ready %b, required 0 and 1", ks_done, keys_ready);
    end
    compute_model(80'd0);
    check_keys("zero_keys");
    n_checks++;
    if (got_keys[0] !== 64'h0 || got_keys[1] !== 64'hC000000000000000 ||
        got_keys[2] !== 64'h5000180000000001) begin
      n_fail++;
      $display("FAIL zero_vectors: got %h %h %h, required 0 C000000000000000 5000180000000001",
               got_keys[0], got_keys[1], got_keys[2]);
    end
    n_checks++;
    if (present_enc(64'd0) !== 64'h5579C1387B228445) begin
      n_fail++;
      $display("FAIL integration_cipher: got %h, required 5579C1387B228445", present_enc(64'd0));
    end
  endtask

  task automatic test_hold();
    rd_en = 1'b1; rd_idx = 5'd3;
    tick();
    rd_en = 1'b0;
    tick();
    n_checks++;
    if (rd_valid !== 1'b0 || rd_data !== exp_keys[3]) begin
      n_fail++;
      $display("FAIL rd_hold: valid %b data %h, required 0 and %h", rd_valid, rd_data, exp_keys[3]);
    end
    tick();
    n_checks++;
    if (rd_data !== exp_keys[3]) begin
      n_fail++;
      $display("FAIL rd_hold2: data %h, required %h", rd_data, exp_keys[3]);
    end
  endtask

  task automatic test_ones_reverse();
    int lat, bc, run, bad;
    run_gen({80{1'b1}}, 0, 80'd0, lat, bc);
    check_gen("ones_latency", lat, bc);
    compute_model({80{1'b1}});
    check_keys("ones_keys");
    n_checks++;
    if (got_keys[0] !== 64'hFFFFFFFFFFFFFFFF) begin
      n_fail++;
      $display("FAIL ones_k1: got %h, required FFFFFFFFFFFFFFFF", got_keys[0]);
    end
    run = 0; bad = 0;
    for (int j = 31; j >= 0; j--) begin
      rd_en = 1'b1; rd_idx = 5'(j);
      tick();
      if (rd_valid === 1'b1) run++;
      if (rd_data !== got_keys[j]) bad++;
    end
    rd_en = 1'b0;
    n_checks++;
    if (run != 32 || bad != 0) begin
      n_fail++;
      $display("FAIL reverse_sweep: %0d valid %0d wrong, required 32 and 0", run, bad);
    end
  endtask

  task automatic test_restart_while_ready();
    logic [63:0] old5;
    logic [79:0] mk;
    int lat, bc;
    old5 = exp_keys[5];
    mk = {16'($urandom), $urandom, $urandom};
    master_key = mk; ks_start = 1'b1; rd_en = 1'b1; rd_idx = 5'd5;
    tick();
    ks_start = 1'b0; rd_en = 1'b0;
    n_checks++;
    if (rd_valid !== 1'b1 || rd_data !== old5 || keys_ready !== 1'b0 || ks_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL restart_read: valid %b data %h ready %b busy %b, required 1 %h 0 1",
               rd_valid, rd_data, keys_ready, ks_busy, old5);
    end
    wait_done(0, 80'd0, lat, bc);
    check_gen("restart_latency", lat, bc);
    compute_model(mk);
    check_keys("restart_keys");
  endtask

  task automatic test_start_ignored();
    int lat, bc;
    run_gen(80'd0, 5, {80{1'b1}} ^ 80'h1234, lat, bc);
    check_gen("ignored_latency", lat, bc);
    compute_model(80'd0);
    check_keys("ignored_keys");
    n_checks++;
    if (got_keys[1] !== 64'hC000000000000000 || got_keys[2] !== 64'h5000180000000001) begin
      n_fail++;
      $display("FAIL ignored_vectors: got %h %h, required C000000000000000 5000180000000001",
               got_keys[1], got_keys[2]);
    end
  endtask

  task automatic test_reset_mid_gen();
    int bad, lat, bc;
    logic [79:0] mk;
    master_key = {16'($urandom), $urandom, $urandom};
    ks_start = 1'b1;
    tick();
    ks_start = 1'b0;
    for (int c = 0; c < 10; c++) tick();
    #2 reset = 1'b1;
    #1;
    n_checks++;
    if ({ks_busy, ks_done, keys_ready, rd_valid} !== 4'b0 || rd_data !== 64'd0) begin
      n_fail++;
      $display("FAIL reset_mid_gen: busy/done/ready/valid %b data %h, required 0000 and 0",
               {ks_busy, ks_done, keys_ready, rd_valid}, rd_data);
    end
    tick(); tick();
    reset = 1'b0;
    bad = 0;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (ks_done !== 1'b0 || keys_ready !== 1'b0 || ks_busy !== 1'b0) bad++;
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL after_abort: %0d cycles with done/ready/busy set, required 0", bad);
    end
    mk = {16'($urandom), $urandom, $urandom};
    run_gen(mk, 0, 80'd0, lat, bc);
    check_gen("post_abort_latency", lat, bc);
    compute_model(mk);
    check_keys("post_abort_keys");
  endtask

  task automatic test_random_keys();
    logic [79:0] mk;
    logic [4:0]  idx;
    int lat, bc, bad;
    for (int t = 0; t < 3; t++) begin
      mk = {16'($urandom), $urandom, $urandom};
      run_gen(mk, 0, 80'd0, lat, bc);
      check_gen("random_latency", lat, bc);
      compute_model(mk);
      bad = 0;
      for (int r = 0; r < 40; r++) begin
        idx = 5'($urandom_range(0, 31));
        rd_en = 1'b1; rd_idx = idx;
        tick();
        if (rd_valid !== 1'b1 || rd_data !== exp_keys[idx]) bad++;
      end
      rd_en = 1'b0;
      n_checks++;
      if (bad != 0) begin
        n_fail++;
        $display("FAIL random_reads key %h: %0d wrong reads, required 0", mk, bad);
      end
    end
  endtask

  initial begin
    test_reset();
    test_read_before_gen();
    test_zero_key();
    test_hold();
    test_ones_reverse();
    test_restart_while_ready();
    test_start_ignored();
    test_reset_mid_gen();
    test_random_keys();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
